// File: rtl/mips_pkg.sv
// Shared writeback-format encodings and stack-pointer defaults for the
// decode-stage register file.
package mips_pkg;

  typedef enum logic [2:0] {
    WB_WORD   = 3'b000,
    WB_HALF_S = 3'b001,
    WB_HALF_U = 3'b010,
    WB_BYTE_S = 3'b011,
    WB_BYTE_U = 3'b100
  } wb_mode_e;

  localparam int          SP_IDX_DEF  = 29;
  localparam logic [31:0] SP_INIT_DEF = 32'h8000_0000;

endpackage

// File: rtl/wb_formatter.sv
// Load-result formatter: selects word/half/byte and sign- or zero-extends.
// Encodings 101-111 fall through to a plain word.
module wb_formatter
  import mips_pkg::*;
#(
  parameter int DATA_W = 32
) (
  input  logic [DATA_W-1:0] wb_data,
  input  logic [2:0]        wb_mode,
  output logic [DATA_W-1:0] fmt_data
);

  always_comb begin
    fmt_data = wb_data;
    case (wb_mode)
      WB_HALF_S: fmt_data = {{(DATA_W-16){wb_data[15]}}, wb_data[15:0]};
      WB_HALF_U: fmt_data = {{(DATA_W-16){1'b0}}, wb_data[15:0]};
      WB_BYTE_S: fmt_data = {{(DATA_W-8){wb_data[7]}}, wb_data[7:0]};
      WB_BYTE_U: fmt_data = {{(DATA_W-8){1'b0}}, wb_data[7:0]};
      default:   fmt_data = wb_data;
    endcase
  end

endmodule

// File: rtl/id_regfile_scoreboard.sv
// Decode-stage register file with per-register 2-bit pending-write counters,
// a writeback-to-read bypass for the last outstanding write, and an immediate extender.
module id_regfile_scoreboard
  import mips_pkg::*;
#(
  parameter int                DATA_W   = 32,
  parameter int                NUM_REGS = 32,
  parameter int                NUM_RD   = 2,
  parameter int                SP_IDX   = SP_IDX_DEF,
  parameter logic [DATA_W-1:0] SP_INIT  = DATA_W'(SP_INIT_DEF),
  localparam int               ADDR_W   = $clog2(NUM_REGS)
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic [NUM_RD*ADDR_W-1:0]   rd_addr,
  output logic [NUM_RD*DATA_W-1:0]   rd_data,
  output logic [NUM_RD-1:0]          rd_ready,
  input  logic                       issue_valid,
  input  logic [ADDR_W-1:0]          issue_dst,
  output logic                       issue_ready,
  input  logic                       wb_valid,
  input  logic [ADDR_W-1:0]          wb_addr,
  input  logic [DATA_W-1:0]          wb_data,
  input  logic [2:0]                 wb_mode,
  input  logic [15:0]                imm_in,
  input  logic                       imm_sign,
  output logic [DATA_W-1:0]          imm_out,
  output logic                       wb_err
);

  logic [DATA_W-1:0] regs [NUM_REGS];
  logic [1:0]        pend [NUM_REGS];
  logic [DATA_W-1:0] wb_fmt;
  logic              wb_hit;
  logic              issue_fire;
  logic [NUM_REGS-1:0] inc_v;
  logic [NUM_REGS-1:0] dec_v;

  // One formatter feeds both the array write and the read bypass so they can never disagree.
  wb_formatter #(.DATA_W(DATA_W)) u_fmt (
    .wb_data  (wb_data),
    .wb_mode  (wb_mode),
    .fmt_data (wb_fmt)
  );

  // Issue handshake: a reservation is taken on a rising edge where
  // issue_valid && issue_ready. issue_ready depends only on issue_dst and the
  // current counters (never on issue_valid); it drops only when the counter is saturated.
  assign issue_ready = (issue_dst == '0) || (pend[issue_dst] != 2'd3);
  assign issue_fire  = issue_valid && issue_ready;
  assign wb_hit      = wb_valid && (wb_addr != '0);

  assign imm_out = imm_sign ? {{(DATA_W-16){imm_in[15]}}, imm_in}
                            : {{(DATA_W-16){1'b0}}, imm_in};

  for (genvar k = 0; k < NUM_RD; k++) begin : g_rd
    logic [ADDR_W-1:0] a;
    logic              byp;
    assign a   = rd_addr[k*ADDR_W +: ADDR_W];
    // Only the last outstanding write may be forwarded; older ones would be overwritten.
    assign byp = wb_valid && (wb_addr == a) && (a != '0) && (pend[a] == 2'd1);
    assign rd_data[k*DATA_W +: DATA_W] = (a == '0) ? '0 : (byp ? wb_fmt : regs[a]);
    assign rd_ready[k] = (a == '0) || (pend[a] == 2'd0) || byp;
  end

  always_comb begin
    inc_v = '0;
    dec_v = '0;
    for (int i = 1; i < NUM_REGS; i++) begin
      inc_v[i] = issue_fire && (issue_dst == ADDR_W'(i));
      dec_v[i] = wb_valid && (wb_addr == ADDR_W'(i)) && (pend[i] != 2'd0);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NUM_REGS; i++) begin
        regs[i] <= (i == SP_IDX) ? SP_INIT : '0;
      end
    end else if (wb_hit) begin
      regs[wb_addr] <= wb_fmt;
    end
  end

  // pend[0] is only ever reset, so register 0 never blocks a reader.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NUM_REGS; i++) begin
        pend[i] <= 2'd0;
      end
      wb_err <= 1'b0;
    end else begin
      for (int i = 1; i < NUM_REGS; i++) begin
        if (inc_v[i] && !dec_v[i]) begin
          pend[i] <= pend[i] + 2'd1;
        end else if (dec_v[i] && !inc_v[i]) begin
          pend[i] <= pend[i] - 2'd1;
        end
      end
      if (wb_hit && (pend[wb_addr] == 2'd0)) begin
        wb_err <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_id_regfile_scoreboard.sv
// Bench for id_regfile_scoreboard: directed scenarios with literal expectations,
// then randomized traffic checked every cycle against an array-based model.
module tb_id_regfile_scoreboard;

  localparam int DW = 32;
  localparam int NR = 32;
  localparam int AW = 5;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic [2*AW-1:0] rd_addr = '0;
  logic [2*DW-1:0] rd_data;
  logic [1:0]    rd_ready;
  logic          issue_valid = 1'b0;
  logic [AW-1:0] issue_dst = '0;
  logic          issue_ready;
  logic          wb_valid = 1'b0;
  logic [AW-1:0] wb_addr = '0;
  logic [DW-1:0] wb_data = '0;
  logic [2:0]    wb_mode = '0;
  logic [15:0]   imm_in = '0;
  logic          imm_sign = 1'b0;
  logic [DW-1:0] imm_out;
  logic          wb_err;

  int errors = 0;
  int checks = 0;
  bit run_cmp = 1'b0;

  logic [DW-1:0] m_regs [NR];
  int            m_pend [NR];
  bit            m_err;
  logic [DW-1:0] exp_q [$];

  id_regfile_scoreboard dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .rd_addr     (rd_addr),
    .rd_data     (rd_data),
    .rd_ready    (rd_ready),
    .issue_valid (issue_valid),
    .issue_dst   (issue_dst),
    .issue_ready (issue_ready),
    .wb_valid    (wb_valid),
    .wb_addr     (wb_addr),
    .wb_data     (wb_data),
    .wb_mode     (wb_mode),
    .imm_in      (imm_in),
    .imm_sign    (imm_sign),
    .imm_out     (imm_out),
    .wb_err      (wb_err)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1);
  end

  // ---------------- model ----------------
  function automatic logic [DW-1:0] fmt(input logic [DW-1:0] d, input logic [2:0] m);
    case (m)
      3'd1:    return {{16{d[15]}}, d[15:0]};
      3'd2:    return {16'h0000, d[15:0]};
      3'd3:    return {{24{d[7]}}, d[7:0]};
      3'd4:    return {24'h000000, d[7:0]};
      default: return d;
    endcase
  endfunction

  task automatic model_reset();
    for (int i = 0; i < NR; i++) begin
      m_regs[i] = (i == 29) ? 32'h8000_0000 : 32'h0;
      m_pend[i] = 0;
    end
    m_err = 1'b0;
  endtask

  always @(posedge clk or negedge rst_n) begin : model_upd
    bit acc;
    bit dec;
    if (!rst_n) begin
      model_reset();
    end else begin
      acc = issue_valid && (issue_dst == 0 || m_pend[issue_dst] != 3);
      dec = wb_valid && wb_addr != 0 && m_pend[wb_addr] > 0;
      if (wb_valid && wb_addr != 0) begin
        m_regs[wb_addr] = fmt(wb_data, wb_mode);
        if (m_pend[wb_addr] == 0) m_err = 1'b1;
      end
      if (acc && issue_dst != 0) m_pend[issue_dst] = m_pend[issue_dst] + 1;
      if (dec) m_pend[wb_addr] = m_pend[wb_addr] - 1;
    end
  end

  // ---------------- scoreboard ----------------
  task automatic chk(input string name, input logic [DW-1:0] got, input logic [DW-1:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, got, exp, $time);
    end
  endtask

  always @(negedge clk) begin : compare
    logic [AW-1:0] a;
    bit            byp;
    logic [DW-1:0] e;
    if (run_cmp) begin
      for (int k = 0; k < 2; k++) begin
        a   = rd_addr[k*AW +: AW];
        byp = wb_valid && wb_addr == a && a != 0 && m_pend[a] == 1;
        exp_q.push_back((a == 0) ? 32'h0 : (byp ? fmt(wb_data, wb_mode) : m_regs[a]));
        chk($sformatf("rd_ready[%0d]", k), 32'(rd_ready[k]),
            32'(a == 0 || m_pend[a] == 0 || byp));
      end
      for (int k = 0; k < 2; k++) begin
        e = exp_q.pop_front();
        chk($sformatf("rd_data[%0d]", k), rd_data[k*DW +: DW], e);
      end
      chk("issue_ready", 32'(issue_ready), 32'(issue_dst == 0 || m_pend[issue_dst] != 3));
      chk("imm_out", imm_out, imm_sign ? {{16{imm_in[15]}}, imm_in} : {16'h0000, imm_in});
      chk("wb_err", 32'(wb_err), 32'(m_err));
    end
  end

  // ---------------- driver tasks ----------------
  task automatic idle();
    issue_valid = 1'b0; issue_dst = '0;
    wb_valid = 1'b0; wb_addr = '0; wb_data = '0; wb_mode = '0;
    rd_addr = '0; imm_in = '0; imm_sign = 1'b0;
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
    idle();
  endtask

  task automatic settle();
    @(negedge clk);
    #1;
  endtask

  task automatic set_rd(input logic [AW-1:0] a0, input logic [AW-1:0] a1);
    rd_addr = {a1, a0};
  endtask

  task automatic do_issue(input logic [AW-1:0] d);
    issue_valid = 1'b1;
    issue_dst = d;
  endtask

  task automatic do_wb(input logic [AW-1:0] a, input logic [DW-1:0] d, input logic [2:0] m);
    wb_valid = 1'b1;
    wb_addr = a;
    wb_data = d;
    wb_mode = m;
  endtask

  function automatic logic [AW-1:0] pick();
    case ($urandom_range(0, 7))
      0: return 5'd0;
      1: return 5'd1;
      2: return 5'd2;
      3: return 5'd3;
      4: return 5'd4;
      5: return 5'd5;
      6: return 5'd29;
      default: return 5'd31;
    endcase
  endfunction

  // ---------------- stimulus ----------------
  logic [DW-1:0] fmt_exp [4];

  initial begin
    fmt_exp[0] = 32'hFFFF_8081;
    fmt_exp[1] = 32'h0000_8081;
    fmt_exp[2] = 32'hFFFF_FF81;
    fmt_exp[3] = 32'h0000_0081;
    idle();
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    run_cmp = 1'b1;

    // reset values, with issue/wb inputs active and ignored
    set_rd(29, 5);
    do_issue(5);
    do_wb(5, 32'hDEAD_BEEF, 3'd0);
    settle();
    chk("rst_sp", rd_data[31:0], 32'h8000_0000);
    chk("rst_r5", rd_data[63:32], 32'h0);
    chk("rst_rd_ready", 32'(rd_ready), 32'h3);
    chk("rst_issue_ready", 32'(issue_ready), 32'h1);
    next_cycle();
    set_rd(5, 29);
    settle();
    chk("rst_ignore_wb", rd_data[31:0], 32'h0);
    chk("rst_wb_err", 32'(wb_err), 32'h0);
    next_cycle();
    rst_n = 1'b1;

    // immediate extension
    imm_in = 16'h8000; imm_sign = 1'b1;
    #1 chk("imm_sext", imm_out, 32'hFFFF_8000);
    imm_sign = 1'b0;
    #1 chk("imm_zext", imm_out, 32'h0000_8000);

    // writeback with no reservation
    next_cycle();
    do_wb(12, 32'hCAFE_F00D, 3'd0);
    settle();
    chk("err_before", 32'(wb_err), 32'h0);
    next_cycle();
    set_rd(12, 0);
    settle();
    chk("err_data", rd_data[31:0], 32'hCAFE_F00D);
    chk("err_set", 32'(wb_err), 32'h1);
    repeat (3) next_cycle();
    settle();
    chk("err_sticky", 32'(wb_err), 32'h1);

    // load formatting
    for (int m = 0; m < 4; m++) begin
      next_cycle();
      do_wb(8, 32'h0000_8081, 3'(m + 1));
      next_cycle();
      set_rd(8, 0);
      settle();
      chk($sformatf("fmt_mode%0d", m + 1), rd_data[31:0], fmt_exp[m]);
    end

    // mid-run reset with a reservation outstanding on reg14
    next_cycle();
    do_wb(5, 32'h5555_5555, 3'd0);
    do_issue(14);
    next_cycle();
    do_wb(29, 32'h0000_0001, 3'd0);
    next_cycle();
    rst_n = 1'b0;
    set_rd(29, 5);
    settle();
    chk("mid_rst_sp", rd_data[31:0], 32'h8000_0000);
    chk("mid_rst_r5", rd_data[63:32], 32'h0);
    chk("mid_rst_ready", 32'(rd_ready), 32'h3);
    chk("mid_rst_err", 32'(wb_err), 32'h0);
    next_cycle();
    rst_n = 1'b1;

    // bypass
    next_cycle();
    do_issue(9);
    settle();
    chk("byp_issue_ready", 32'(issue_ready), 32'h1);
    next_cycle();
    set_rd(9, 0);
    #1 chk("byp_pending", 32'(rd_ready[0]), 32'h0);
    do_wb(9, 32'h0000_1234, 3'd0);
    settle();
    chk("byp_data", rd_data[31:0], 32'h0000_1234);
    chk("byp_ready", 32'(rd_ready[0]), 32'h1);

    // saturation of reg10
    for (int i = 0; i < 3; i++) begin
      next_cycle();
      do_issue(10);
      settle();
      chk("sat_issue_ok", 32'(issue_ready), 32'h1);
    end
    next_cycle();
    do_issue(10);
    set_rd(10, 0);
    settle();
    chk("sat_full", 32'(issue_ready), 32'h0);
    chk("sat_rd_ready3", 32'(rd_ready[0]), 32'h0);
    next_cycle();
    do_wb(10, 32'h0000_00A1, 3'd0);
    issue_dst = 10;
    set_rd(10, 0);
    settle();
    chk("sat_wb1_noby", 32'(rd_ready[0]), 32'h0);
    next_cycle();
    issue_dst = 10;
    set_rd(10, 0);
    settle();
    chk("sat_reopen", 32'(issue_ready), 32'h1);
    chk("sat_rd_ready2", 32'(rd_ready[0]), 32'h0);
    next_cycle();
    do_wb(10, 32'h0000_00A2, 3'd0);
    set_rd(10, 0);
    settle();
    chk("sat_wb2_ready", 32'(rd_ready[0]), 32'h0);
    chk("sat_wb2_data", rd_data[31:0], 32'h0000_00A1);
    next_cycle();
    do_wb(10, 32'h0000_00A3, 3'd0);
    set_rd(10, 0);
    settle();
    chk("sat_wb3_ready", 32'(rd_ready[0]), 32'h1);
    chk("sat_wb3_data", rd_data[31:0], 32'h0000_00A3);

    // simultaneous issue + writeback on reg11
    next_cycle();
    do_issue(11);
    next_cycle();
    do_issue(11);
    do_wb(11, 32'h0000_0055, 3'd0);
    set_rd(11, 0);
    settle();
    chk("sim_byp_data", rd_data[31:0], 32'h0000_0055);
    next_cycle();
    set_rd(11, 0);
    settle();
    chk("sim_still_pend", 32'(rd_ready[0]), 32'h0);
    chk("sim_stored", rd_data[31:0], 32'h0000_0055);
    next_cycle();
    do_wb(11, 32'h0000_0066, 3'd0);
    next_cycle();
    set_rd(11, 0);
    settle();
    chk("sim_clear", 32'(rd_ready[0]), 32'h1);

    // writes to register 0 are discarded
    next_cycle();
    do_wb(0, 32'hFFFF_FFFF, 3'd0);
    next_cycle();
    set_rd(0, 0);
    settle();
    chk("r0_data", rd_data[31:0], 32'h0);
    chk("r0_err", 32'(wb_err), 32'h0);

    // reservation on reg14 was dropped by reset
    next_cycle();
    do_wb(14, 32'h0000_0077, 3'd0);
    next_cycle();
    set_rd(14, 0);
    settle();
    chk("stale_wb_data", rd_data[31:0], 32'h0000_0077);
    chk("stale_wb_err", 32'(wb_err), 32'h1);

    // randomized traffic
    for (int n = 0; n < 2000; n++) begin
      next_cycle();
      rst_n = (n % 600 == 599) ? 1'b0 : 1'b1;
      issue_valid = 1'($urandom_range(0, 1));
      issue_dst = pick();
      wb_addr = pick();
      wb_valid = (m_pend[wb_addr] > 0) ? 1'($urandom_range(0, 2) != 0)
                                       : 1'($urandom_range(0, 15) == 0);
      wb_data = $urandom;
      wb_mode = 3'($urandom_range(0, 7));
      set_rd(($urandom_range(0, 1) != 0) ? wb_addr : pick(), pick());
      imm_in = 16'($urandom_range(0, 65535));
      imm_sign = 1'($urandom_range(0, 1));
    end
    next_cycle();
    rst_n = 1'b1;
    settle();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/id_regfile_scoreboard.md
ID_REGFILE_SCOREBOARD -- requirements
Module: id_regfile_scoreboard

Interface
REQ-001 SHALL have parameter DATA_W, default 32, register width in bits.
REQ-002 SHALL have parameter NUM_REGS, default 32, register count; ADDR_W = clog2(NUM_REGS).
REQ-003 SHALL have parameter NUM_RD, default 2, number of read ports.
REQ-004 SHALL have parameter SP_IDX, default 29, index of the stack-pointer register.
REQ-005 SHALL have parameter SP_INIT, default 32'h8000_0000, stack-pointer reset value.
REQ-006 SHALL have port clk  input  1  single clock; all state updates on its rising edge.
REQ-007 SHALL have port rst_n  input  1  reset, asynchronous, active-low.
REQ-008 SHALL have port rd_addr  input  NUM_RD*ADDR_W  packed read addresses; port k at [k*ADDR_W +: ADDR_W].
REQ-009 SHALL have port rd_data  output  NUM_RD*DATA_W  packed read data.
REQ-010 SHALL have port rd_ready  output  NUM_RD  per port, operand valid (no unresolved pending write).
REQ-011 SHALL have ports issue_valid  input  1, issue_dst  input  ADDR_W, issue_ready  output  1: destination reservation handshake.
REQ-012 SHALL have ports wb_valid  input  1, wb_addr  input  ADDR_W, wb_data  input  DATA_W, wb_mode  input  3: writeback.
REQ-013 SHALL have ports imm_in  input  16, imm_sign  input  1, imm_out  output  DATA_W: immediate extender.
REQ-014 SHALL have port wb_err  output  1  sticky writeback-without-reservation flag.

Function
REQ-015 SHALL read combinationally: rd_data[k] = reg[rd_addr[k]], address 0 always reads 0.
REQ-016 SHALL format wb_data by wb_mode: 000 word; 001 half signed; 010 half unsigned; 011 byte signed; 100 byte unsigned; 101-111 treated as word. Half/byte use the low 16/8 bits; extension to DATA_W.
REQ-017 SHALL write the formatted value on the clock edge when wb_valid=1 and wb_addr!=0; writes to address 0 discarded.
REQ-018 SHALL hold a 2-bit pending counter per register; register 0 counter is constant 0.
REQ-019 SHALL drive issue_ready = 1 when issue_dst=0 or pending[issue_dst]!=3; issue accepted when issue_valid && issue_ready.
REQ-020 SHALL update pending[r] per edge: +1 on accepted issue to r, -1 on wb_valid to r with pending>0, unchanged when both occur for the same r.
REQ-021 SHALL, on wb_valid to r with pending[r]=0 (and r!=0), still write data, keep counter 0, and set wb_err=1 until reset.
REQ-022 SHALL drive rd_ready[k]=1 when pending[rd_addr[k]]=0, or when bypassing (REQ-023); else 0; address 0 always ready.
REQ-023 SHALL bypass: when wb_valid, wb_addr=rd_addr[k]!=0 and pending[rd_addr[k]]=1, rd_data[k] = formatted wb_data same cycle and rd_ready[k]=1.
REQ-024 SHALL not bypass when pending>1; rd_data[k] then shows stored value with rd_ready[k]=0.
REQ-025 SHALL produce imm_out = imm_in sign-extended when imm_sign=1, zero-extended when 0; purely combinational.
REQ-026 SHALL guarantee zero-cycle read latency and one-cycle write latency (written value visible from stored array on the following cycle).

Reset
REQ-027 SHALL, while rst_n=0, force all registers to 0 except reg[SP_IDX]=SP_INIT, all pending counters to 0, wb_err=0, independent of clk.
REQ-028 SHALL, during reset, drive rd_data from reset values, rd_ready all 1, issue_ready 1; issue/wb inputs ignored.
REQ-029 SHALL discard any outstanding reservations on reset mid-operation; a later wb to a formerly reserved register sets wb_err.

Structure
REQ-030 SHALL place wb_mode encodings (WB_WORD, WB_HALF_S, WB_HALF_U, WB_BYTE_S, WB_BYTE_U) and default SP constants in shared package mips_pkg.
REQ-031 SHALL implement load formatting in one sub-module wb_formatter (wb_data, wb_mode -> formatted data), used for both write and bypass paths.

Verification
REQ-032 SHALL cover reset: assert rst_n=0 mid-run -> reg29 reads 32'h8000_0000, reg5 reads 0, rd_ready=2'b11, wb_err=0.
REQ-033 SHALL cover formatting: wb reg8 data 32'h0000_8081 modes 001/010/011/100 -> reads 32'hFFFF_8081, 32'h0000_8081, 32'hFFFF_FF81, 32'h0000_0081.
REQ-034 SHALL cover bypass: issue dst 9, next cycle wb reg9 32'h1234 while rd_addr[0]=9 -> rd_data[0]=32'h1234, rd_ready[0]=1 same cycle.
REQ-035 SHALL cover saturation: three issues to reg10 -> issue_ready=0 for dst 10, fourth issue ignored; one wb -> issue_ready=1, rd_ready for 10 stays 0 until third wb (bypassed).
REQ-036 SHALL cover simultaneous issue+wb to reg11 with pending=1 -> pending stays 1, rd_ready=0 next cycle; and wb to reg0 -> reads 0, wb_err unchanged.
REQ-037 SHALL cover error: wb reg12 with no reservation -> data written, wb_err=1 held until rst_n low; imm_in 16'h8000 imm_sign 1/0 -> 32'hFFFF_8000 / 32'h0000_8000.
